// File: rtl/key_digit_scanner.sv
// Scalar-key digit scanner: loads a KEY_W-bit key and presents it one DIGIT_W digit at a time.
// First digit 1 cycle after i_load (plus skip cycles); o_digit/o_idx hold until i_next while o_valid.
module key_digit_scanner #(
  parameter int KEY_W     = 256,
  parameter int DIGIT_W   = 1,
  parameter int MSB_FIRST = 1,
  parameter int SKIP_LZ   = 1,
  localparam int NDIG     = KEY_W / DIGIT_W,
  localparam int IW       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [KEY_W-1:0]   i_key,
  input  logic               i_next,
  output logic [DIGIT_W-1:0] o_digit,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {IDLE, SKIP, PRESENT, DONE} state_t;

  localparam bit MSBF  = (MSB_FIRST != 0);
  localparam bit SKIPF = MSBF && (SKIP_LZ != 0);
  localparam logic [IW-1:0] IDX_FIRST = MSBF ? IW'(NDIG - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST  = MSBF ? '0 : IW'(NDIG - 1);

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   sr_q, sr_d, sr_step;
  logic [IW-1:0]      idx_d, idx_step;
  logic [DIGIT_W-1:0] top_dig, dig_d;

  assign top_dig  = sr_q[KEY_W-1 -: DIGIT_W];
  assign sr_step  = MSBF ? (sr_q << DIGIT_W) : (sr_q >> DIGIT_W);
  assign idx_step = MSBF ? (o_idx - IW'(1)) : (o_idx + IW'(1));

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = o_idx;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          sr_d    = i_key;
          idx_d   = IDX_FIRST;
          state_d = SKIPF ? SKIP : PRESENT;
        end
      end
      SKIP: begin
        // Digit 0 is never skipped, so a zero key still presents one digit.
        if (top_dig == '0 && o_idx != '0) begin
          sr_d  = sr_step;
          idx_d = idx_step;
        end else begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (i_next) begin
          if (o_idx == IDX_LAST) begin
            state_d = DONE;
          end else begin
            sr_d  = sr_step;
            idx_d = idx_step;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dig_d = MSBF ? sr_d[KEY_W-1 -: DIGIT_W] : sr_d[DIGIT_W-1:0];
  end

  // Outputs are registered from the next-state values so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      o_idx   <= '0;
      o_digit <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      o_idx   <= idx_d;
      o_digit <= dig_d;
      o_valid <= (state_d == PRESENT);
      o_last  <= (state_d == PRESENT) && (idx_d == IDX_LAST);
      o_busy  <= (state_d != IDLE);
      o_done  <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_key_digit_scanner.sv
// Bench for key_digit_scanner: four configurations, observed through one selectable view.
module tb_key_digit_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         load_m, next_m;
  logic [255:0] key_m;
  int           sel;
  int           total = 0;
  int           bad   = 0;

  logic a_load, a_next, a_valid, a_last, a_busy, a_done;
  logic [0:0] a_digit;
  logic [2:0] a_idx;
  logic b_load, b_next, b_valid, b_last, b_busy, b_done;
  logic [1:0] b_digit;
  logic [1:0] b_idx;
  logic c_load, c_next, c_valid, c_last, c_busy, c_done;
  logic [0:0] c_digit;
  logic [2:0] c_idx;
  logic d_load, d_next, d_valid, d_last, d_busy, d_done;
  logic [0:0] d_digit;
  logic [7:0] d_idx;

  assign a_load = load_m && (sel == 0);
  assign a_next = next_m && (sel == 0);
  assign b_load = load_m && (sel == 1);
  assign b_next = next_m && (sel == 1);
  assign c_load = load_m && (sel == 2);
  assign c_next = next_m && (sel == 2);
  assign d_load = load_m && (sel == 3);
  assign d_next = next_m && (sel == 3);

  key_digit_scanner #(.KEY_W(8), .DIGIT_W(1), .MSB_FIRST(1), .SKIP_LZ(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(a_load), .i_key(key_m[7:0]), .i_next(a_next),
    .o_digit(a_digit), .o_idx(a_idx), .o_valid(a_valid), .o_last(a_last),
    .o_busy(a_busy), .o_done(a_done));

  key_digit_scanner #(.KEY_W(8), .DIGIT_W(2), .MSB_FIRST(0), .SKIP_LZ(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(b_load), .i_key(key_m[7:0]), .i_next(b_next),
    .o_digit(b_digit), .o_idx(b_idx), .o_valid(b_valid), .o_last(b_last),
    .o_busy(b_busy), .o_done(b_done));

  key_digit_scanner #(.KEY_W(8), .DIGIT_W(1), .MSB_FIRST(1), .SKIP_LZ(0)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(c_load), .i_key(key_m[7:0]), .i_next(c_next),
    .o_digit(c_digit), .o_idx(c_idx), .o_valid(c_valid), .o_last(c_last),
    .o_busy(c_busy), .o_done(c_done));

  key_digit_scanner #(.KEY_W(256), .DIGIT_W(1), .MSB_FIRST(1), .SKIP_LZ(1)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(d_load), .i_key(key_m), .i_next(d_next),
    .o_digit(d_digit), .o_idx(d_idx), .o_valid(d_valid), .o_last(d_last),
    .o_busy(d_busy), .o_done(d_done));

  logic [1:0] m_digit;
  logic [7:0] m_idx;
  logic       m_valid, m_last, m_busy, m_done;

  always_comb begin
    m_digit = '0;
    m_idx   = '0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    case (sel)
      0: begin
        m_digit = {1'b0, a_digit}; m_idx = {5'b0, a_idx};
        m_valid = a_valid; m_last = a_last; m_busy = a_busy; m_done = a_done;
      end
      1: begin
        m_digit = b_digit; m_idx = {6'b0, b_idx};
        m_valid = b_valid; m_last = b_last; m_busy = b_busy; m_done = b_done;
      end
      2: begin
        m_digit = {1'b0, c_digit}; m_idx = {5'b0, c_idx};
        m_valid = c_valid; m_last = c_last; m_busy = c_busy; m_done = c_done;
      end
      default: begin
        m_digit = {1'b0, d_digit}; m_idx = d_idx;
        m_valid = d_valid; m_last = d_last; m_busy = d_busy; m_done = d_done;
      end
    endcase
  end

  int cfg_kw[4]   = '{8, 8, 8, 256};
  int cfg_dw[4]   = '{1, 2, 1, 1};
  int cfg_msb[4]  = '{1, 0, 1, 1};
  int cfg_skip[4] = '{1, 1, 0, 1};

  // Full scan of one key on instance s. mode 0: i_next always 1; 1: random stalls and
  // stray loads; 2: five stalls on the first digit while a load of all-ones is attempted.
  task automatic scan(input int s, input logic [255:0] key, input int mode, input string tag);
    int kw, dw, ndig, start, lat, cyc, j, guard, stall;
    bit msb, skp, nx;
    int dg[256];
    int exp_idx[$];
    int exp_dig[$];
    logic [255:0] kmask, acc, tmp;
    kw = cfg_kw[s]; dw = cfg_dw[s]; msb = (cfg_msb[s] != 0); skp = (cfg_skip[s] != 0);
    ndig  = kw / dw;
    kmask = (kw == 256) ? '1 : ((256'd1 << kw) - 256'd1);
    key   = key & kmask;
    for (int i = 0; i < ndig; i++) begin
      tmp   = key >> (i * dw);
      dg[i] = int'(tmp[1:0]) & ((1 << dw) - 1);
    end
    start = ndig - 1;
    if (msb) begin
      if (skp) while (start > 0 && dg[start] == 0) start--;
      for (int i = start; i >= 0; i--) begin exp_idx.push_back(i); exp_dig.push_back(dg[i]); end
    end else begin
      for (int i = 0; i < ndig; i++) begin exp_idx.push_back(i); exp_dig.push_back(dg[i]); end
    end
    lat = (msb && skp) ? (ndig - start) : 0;

    sel = s;
    @(negedge clk);
    key_m = key; load_m = 1'b1; next_m = 1'b0;
    @(negedge clk);
    load_m = 1'b0;
    cyc = 0;
    while (m_valid !== 1'b1 && cyc < ndig + 4) begin
      total++;
      if (m_busy !== 1'b1 || m_done !== 1'b0) begin
        bad++;
        $display("FAIL %s wait: busy=%b done=%b want busy=1 done=0", tag, m_busy, m_done);
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != lat) begin
      bad++;
      $display("FAIL %s first-valid latency: got %0d cycles want %0d", tag, cyc, lat);
    end

    acc = '0; j = 0; guard = 0; stall = 0;
    while (j < exp_idx.size() && guard < 4 * ndig + 40) begin
      guard++;
      total++;
      if (m_valid !== 1'b1 || m_digit !== 2'(exp_dig[j]) || m_idx !== 8'(exp_idx[j]) ||
          m_last !== (j == exp_idx.size() - 1) || m_done !== 1'b0) begin
        bad++;
        $display("FAIL %s digit %0d: valid=%b digit=%0d idx=%0d last=%b done=%b want 1/%0d/%0d/%0b/0",
                 tag, j, m_valid, m_digit, m_idx, m_last, m_done, exp_dig[j], exp_idx[j],
                 (j == exp_idx.size() - 1));
      end
      case (mode)
        0:       nx = 1'b1;
        1:       nx = ($urandom_range(0, 2) != 0);
        default: nx = (stall >= 5);
      endcase
      if (mode == 1) begin
        load_m = ($urandom_range(0, 1) != 0);
        key_m  = {8{$urandom}};
      end else if (mode == 2) begin
        load_m = !nx;
        key_m  = '1;
      end
      if (nx) acc = acc | (256'(m_digit) << (int'(m_idx) * dw));
      else stall++;
      next_m = nx;
      @(negedge clk);
      if (nx) j++;
    end
    next_m = 1'b0;
    total++;
    if (m_valid !== 1'b0 || m_done !== 1'b1 || m_busy !== 1'b1) begin
      bad++;
      $display("FAIL %s done cycle: valid=%b done=%b busy=%b want 0/1/1", tag, m_valid, m_done, m_busy);
    end
    load_m = 1'b1;
    key_m  = {8{$urandom}};
    @(negedge clk);
    load_m = 1'b0;
    total++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_valid !== 1'b0 || m_idx !== 8'(exp_idx[$])) begin
      bad++;
      $display("FAIL %s after done: done=%b busy=%b valid=%b idx=%0d want 0/0/0/%0d",
               tag, m_done, m_busy, m_valid, m_idx, exp_idx[$]);
    end
    total++;
    if (acc !== key) begin
      bad++;
      $display("FAIL %s reassembly: got %h want %h", tag, acc, key);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_m = 1'b0; next_m = 1'b0; key_m = '0; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      total++;
      if ({m_valid, m_last, m_busy, m_done} !== 4'b0 || m_digit !== 2'b0 || m_idx !== 8'b0) begin
        bad++;
        $display("FAIL reset inst%0d: valid=%b last=%b busy=%b done=%b digit=%0d idx=%0d want all 0",
                 s, m_valid, m_last, m_busy, m_done, m_digit, m_idx);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_skip_msb();
    scan(0, 256'h15, 0, "skip_15");
  endtask

  task automatic test_zero_key();
    scan(0, 256'h00, 0, "zero_key");
  endtask

  task automatic test_lsb_digit2();
    scan(1, 256'hB4, 0, "lsb_b4");
  endtask

  task automatic test_stall_load_ignored();
    scan(2, 256'h80, 2, "stall_80");
  endtask

  task automatic test_reset_midscan();
    int cyc;
    sel = 0;
    @(negedge clk);
    key_m = 256'hFF; load_m = 1'b1; next_m = 1'b0;
    @(negedge clk);
    load_m = 1'b0; next_m = 1'b1;
    cyc = 0;
    while (!(m_valid === 1'b1 && m_idx === 8'd3) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc >= 30) begin
      bad++;
      $display("FAIL midscan reach idx3: idx=%0d valid=%b want idx=3 valid=1", m_idx, m_valid);
    end
    rst_n = 1'b0; next_m = 1'b0;
    @(negedge clk);
    total++;
    if ({m_valid, m_last, m_busy, m_done} !== 4'b0 || m_digit !== 2'b0 || m_idx !== 8'b0) begin
      bad++;
      $display("FAIL midscan reset: valid=%b last=%b busy=%b done=%b digit=%0d idx=%0d want all 0",
               m_valid, m_last, m_busy, m_done, m_digit, m_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (m_busy !== 1'b0 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL midscan idle: busy=%b valid=%b want 0/0", m_busy, m_valid);
    end
    scan(0, 256'h01, 0, "reload_01");
  endtask

  task automatic test_random_small();
    for (int n = 0; n < 6; n++) begin
      scan(0, 256'($urandom_range(0, 255)), 1, "rand_a");
      scan(1, 256'($urandom_range(0, 255)), 1, "rand_b");
      scan(2, 256'($urandom_range(0, 255)), 1, "rand_c");
    end
  endtask

  task automatic test_random_256();
    logic [255:0] k;
    for (int n = 0; n < 3; n++) begin
      for (int w = 0; w < 8; w++) k[w*32 +: 32] = $urandom;
      k = k >> $urandom_range(0, 40);
      scan(3, k, 1, "rand_256");
    end
  endtask

  initial begin
    test_reset();
    test_skip_msb();
    test_zero_key();
    test_lsb_digit2();
    test_stall_load_ignored();
    test_reset_midscan();
    test_random_small();
    test_random_256();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
